csa_resolver: RTL and testbench
===============================

Name: csa_resolver

Overview:
- Carry-propagate back end for our compressor trees: takes a redundant (sum, carry) vector pair and resolves it to a binary result.
- Works iteratively, CHUNK bits per cycle, with a rippled chunk carry, so that wide operands do not need a single-cycle full-width adder.
- Sits after the multiplier/accumulator compression stages. Valid/ready handshake on both sides.

Parameters:
- WIDTH, 32: operand and result width in bits.
- CHUNK, 8: bits resolved per cycle. WIDTH % CHUNK must be 0, otherwise elaboration error. NCHUNK = WIDTH/CHUNK.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept an operand pair.
- in_sum  input  WIDTH  sum vector; bit i has weight 2^i.
- in_carry  input  WIDTH  carry vector, pre-aligned by the producer; bit i has weight 2^i.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_result  output  WIDTH  (in_sum + in_carry) mod 2^WIDTH.
- out_cout  output  1  bit WIDTH of in_sum + in_carry.

Behaviour:
- Reset:
  - Synchronous and active-high: rst is sampled only on a rising clk edge.
  - Reset puts the state machine in IDLE, chunk index 0 and chunk carry 0.
  - Reset values: out_valid 0, out_result 0, out_cout 0.
  - in_ready = (state==IDLE) & ~rst, so it is 0 while rst is high.
- State machine IDLE / BUSY / DONE, one transaction in flight at a time:
  - IDLE:
    - in_ready=1, out_valid=0.
    - On in_valid & in_ready: latch in_sum and in_carry; clear chunk index and chunk carry; go to BUSY.
  - BUSY:
    - in_ready=0, out_valid=0.
    - Each cycle, for chunk k = index:
      - {c, r} = sum[k] + carry[k] + c, a CHUNK+1-bit add.
      - Write r into out_result bits [k*CHUNK +: CHUNK].
      - Increment index.
    - After chunk NCHUNK-1: out_cout = final c; go to DONE.
  - DONE:
    - out_valid=1; out_result and out_cout held stable.
    - in_ready=0; in_valid is ignored and no operand is captured.
    - On out_valid & out_ready: go to IDLE, out_valid 0 next cycle.
- Latency:
  - Operands accepted at edge T; out_valid is high from edge T+NCHUNK.
  - Minimum spacing between accepts is NCHUNK+2 cycles when out_ready is tied high.
  - CHUNK==WIDTH is legal and gives single-chunk operation: out_valid from edge T+1.
- Outputs change only while in BUSY, and out_result is not cleared on accept. Consumers sample only under out_valid.
- Reset during BUSY or DONE: the transaction is discarded, out_valid deasserts at that edge and is never raised for it, and the state returns to IDLE.
- rst has priority over any handshake in the same cycle.
- Arithmetic is unsigned. Signed use is the caller's concern: ignore out_cout and take out_result mod 2^WIDTH.

Test Plan (WIDTH=32, CHUNK=8):
- Reset: hold rst 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, out_result=0, out_cout=0; no capture; in_ready=1 the first cycle after rst drops.
- Full ripple: sum=0xFFFFFFFF, carry=0x00000001 -> out_result=0x00000000, out_cout=1, out_valid exactly 4 cycles after accept.
- Cross-chunk carry and plain add:
  - sum=0x00FFFFFF, carry=0x00000001 -> 0x01000000, cout=0.
  - sum=0x12345678, carry=0x11111111 -> 0x23456789, cout=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving a new in_valid -> outputs stable, in_ready=0, new operands not captured; accept only after the output handshake, in_ready=1 one cycle later.
- Back-to-back with out_ready=1: random 200 pairs -> each result equals the 33-bit sum {out_cout, out_result}; accept spacing is 6 cycles.
- Reset mid-op: assert rst on the 2nd BUSY cycle of sum=0xAAAAAAAA, carry=0x55555555 -> out_valid never rises; next transaction 1+1 gives result 2, cout=0.

Source files
------------

// File: rtl/csa_resolver.sv
// Iterative carry-propagate resolver for a redundant (sum, carry) pair.
// Resolves CHUNK bits per cycle with a rippled chunk carry; valid/ready on both sides.
module csa_resolver #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_cout
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDXW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  if (WIDTH % CHUNK != 0) begin : g_chunk_check
    $error("csa_resolver: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           state_q;
  logic [IDXW-1:0]  idx_q;
  logic             cy_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] carry_q;
  logic [CHUNK:0]   chunk_add;

  // One CHUNK+1-bit add per cycle; the top bit feeds the next chunk.
  assign chunk_add = {1'b0, sum_q[idx_q*CHUNK +: CHUNK]}
                   + {1'b0, carry_q[idx_q*CHUNK +: CHUNK]}
                   + {{CHUNK{1'b0}}, cy_q};

  assign in_ready = (state_q == StIdle) & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      cy_q       <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_cout   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            sum_q   <= in_sum;
            carry_q <= in_carry;
            idx_q   <= '0;
            cy_q    <= 1'b0;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          out_result[idx_q*CHUNK +: CHUNK] <= chunk_add[CHUNK-1:0];
          cy_q  <= chunk_add[CHUNK];
          idx_q <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            out_cout  <= chunk_add[CHUNK];
            out_valid <= 1'b1;
            state_q   <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_resolver.sv
// Scoreboard bench for csa_resolver: expected sums queued at accept, compared at output handshake.
module tb_csa_resolver;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned CHUNK  = 8;
  localparam int unsigned NCHUNK = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_sum;
  logic [WIDTH-1:0] in_carry;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_cout;

  int          checks = 0;
  int          errors = 0;
  longint      cyc = 0;
  longint      acc_cyc = 0;
  logic [WIDTH:0] exp_q[$];
  logic [WIDTH:0] mon_exp;

  csa_resolver #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sum     (in_sum),
    .in_carry   (in_carry),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_cout   (out_cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output monitor: a handshake will complete at the next edge, so compare now.
  always @(posedge clk) begin
    #2;
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_underflow", 64'(out_valid), 64'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check_eq("result", 64'({out_cout, out_result}), 64'(mon_exp));
      end
    end
  end

  task automatic accept(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c, input bit push);
    int n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (in_ready !== 1'b1) check_eq("ready_timeout", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_sum   = s;
    in_carry = c;
    if (push) exp_q.push_back({1'b0, s} + {1'b0, c});
    tick();
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    if (out_valid !== 1'b1) check_eq("valid_timeout", 64'(out_valid), 64'd1);
  endtask

  // Accept, wait for the result, then let the output handshake complete.
  task automatic run(input string tag, input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c);
    int lat;
    accept(s, c, 1'b1);
    wait_valid(lat);
    check_eq(tag, 64'(lat), 64'(NCHUNK));
    tick();
  endtask

  initial begin
    int     lat;
    bit     seen;
    longint prev;

    rst       = 1'b1;
    in_valid  = 1'b1;
    in_sum    = 32'hDEADBEEF;
    in_carry  = 32'h00000001;
    out_ready = 1'b1;

    repeat (3) begin
      tick();
      check_eq("rst_in_ready", 64'(in_ready), 64'd0);
      check_eq("rst_out_valid", 64'(out_valid), 64'd0);
      check_eq("rst_out_result", 64'(out_result), 64'd0);
      check_eq("rst_out_cout", 64'(out_cout), 64'd0);
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    check_eq("post_rst_in_ready", 64'(in_ready), 64'd1);
    tick();
    check_eq("no_capture_valid", 64'(out_valid), 64'd0);
    check_eq("no_capture_ready", 64'(in_ready), 64'd1);

    run("lat_full_ripple", 32'hFFFFFFFF, 32'h00000001);
    run("lat_cross_chunk", 32'h00FFFFFF, 32'h00000001);
    run("lat_plain_add", 32'h12345678, 32'h11111111);

    // Backpressure: result must hold and new operands must wait.
    out_ready = 1'b0;
    accept(32'h0F0F0F0F, 32'h01010101, 1'b1);
    wait_valid(lat);
    check_eq("lat_bp", 64'(lat), 64'(NCHUNK));
    in_valid = 1'b1;
    in_sum   = 32'h11111111;
    in_carry = 32'h22222222;
    repeat (5) begin
      tick();
      check_eq("bp_out_valid", 64'(out_valid), 64'd1);
      check_eq("bp_in_ready", 64'(in_ready), 64'd0);
      check_eq("bp_out_result", 64'(out_result), 64'h10101010);
      check_eq("bp_out_cout", 64'(out_cout), 64'd0);
    end
    out_ready = 1'b1;
    exp_q.push_back({1'b0, 32'h11111111} + {1'b0, 32'h22222222});
    tick();
    check_eq("bp_release_valid", 64'(out_valid), 64'd0);
    check_eq("bp_release_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    wait_valid(lat);
    check_eq("lat_after_bp", 64'(lat), 64'(NCHUNK));
    tick();

    // Reset on the second BUSY cycle discards the transaction.
    accept(32'hAAAAAAAA, 32'h55555555, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
    check_eq("midrst_in_ready", 64'(in_ready), 64'd0);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      tick();
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    check_eq("midrst_never_valid", 64'(seen), 64'd0);
    run("lat_after_midrst", 32'h00000001, 32'h00000001);

    prev = acc_cyc;
    for (int i = 0; i < 200; i++) begin
      run("lat_rand", $urandom, $urandom);
      check_eq("accept_spacing", 64'(acc_cyc - prev), 64'(NCHUNK + 2));
      prev = acc_cyc;
    end

    repeat (3) tick();
    check_eq("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
